// File: rtl/gyruss_audio_pkg.sv
// Shared types and constants for the time-multiplexed Gyruss audio low-pass filter.
// Coefficients are Q15, and every filter has a DC gain of exactly 1.
package gyruss_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SHIFT    = 15;
  localparam int COEF_W   = 18;
  localparam int ACC_W    = 36;

  typedef enum logic [1:0] {BYPASS, LIGHT, MEDIUM, HEAVY} fsel_e;

  typedef enum logic [2:0] {IDLE, LOAD, MB1, MB2, MA2, WB, PUB} state_e;

  typedef enum logic [1:0] {MAC_HOLD, MAC_CLR_ADD, MAC_ADD, MAC_SUB} mac_op_e;

  typedef struct packed {
    logic signed [COEF_W-1:0] a2;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
  } coef_t;

  // Each entry satisfies b1 + b2 == 32768 + a2.
  function automatic coef_t coef_lut(input fsel_e s);
    coef_t c;
    c = '0;
    case (s)
      LIGHT:   c = '{a2: -18'sd16384, b1: 18'sd8192, b2: 18'sd8192};
      MEDIUM:  c = '{a2: -18'sd32420, b1: 18'sd174,  b2: 18'sd174};
      HEAVY:   c = '{a2: -18'sd32700, b1: 18'sd34,   b2: 18'sd34};
      default: c = '0;
    endcase
    return c;
  endfunction

  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> SHIFT;
    if (s > SAT_MAX)      return 16'sh7fff;
    else if (s < SAT_MIN) return 16'sh8000;
    else                  return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/gyruss_lpf_scheduler_if.sv
// Sample/select inputs and filtered outputs of the LPF scheduler.
interface gyruss_lpf_scheduler_if import gyruss_audio_pkg::*; #(parameter int NCH = 5);
  logic [NCH*SAMPLE_W-1:0] in_flat;
  logic [NCH*2-1:0]        sel_flat;
  logic [NCH*SAMPLE_W-1:0] out_flat;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  modport master (output in_flat, sel_flat, input out_flat, out_valid, busy, overrun);
  modport slave  (input in_flat, sel_flat, output out_flat, out_valid, busy, overrun);
endinterface

// File: rtl/gyruss_iir_mac.sv
// Single shared multiplier with a registered product feeding a clear/add/sub accumulator.
module gyruss_iir_mac import gyruss_audio_pkg::*; #(
  parameter int CW = COEF_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [CW-1:0]       b,
  input  mac_op_e                    op,
  output logic signed [ACC_W-1:0]    acc
);
  localparam int PW = SAMPLE_W + CW;

  logic signed [PW-1:0]    prod_d, prod_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    prod_d = PW'(a) * PW'(b);
    acc_d  = acc_q;
    case (op)
      MAC_CLR_ADD: acc_d = ACC_W'(prod_q);
      MAC_ADD:     acc_d = acc_q + ACC_W'(prod_q);
      MAC_SUB:     acc_d = acc_q - ACC_W'(prod_q);
      default:     acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/gyruss_lpf_scheduler.sv
// Runs NCH channels through one shared first-order IIR MAC per sample tick and
// publishes every result together. Needs DIV >= 5*NCH+2 for overrun-free operation.
module gyruss_lpf_scheduler import gyruss_audio_pkg::*; #(
  parameter int NCH = 5,
  parameter int DIV = 220,
  parameter int CW  = COEF_W
) (
  input logic             clk,
  input logic             reset_n,
  gyruss_lpf_scheduler_if.slave bus
);
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef logic [NCH-1:0][SAMPLE_W-1:0] vec_t;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [KW-1:0]    k_q, k_d;
  vec_t             snap_q, snap_d, x1_q, x1_d, y1_q, y1_d, res_q, res_d, out_q, out_d;
  logic [NCH-1:0][1:0] sel_q, sel_d;
  logic             busy_q, busy_d, vld_q, vld_d, ovr_q, ovr_d;

  logic                       tick;
  fsel_e                      sel_cur;
  coef_t                      coef;
  logic signed [SAMPLE_W-1:0] x_cur, y_wb, mac_a;
  logic signed [CW-1:0]       mac_b;
  mac_op_e                    mac_op;
  logic signed [ACC_W-1:0]    acc;

  assign tick    = (div_q == DW'(DIV-1));
  assign sel_cur = fsel_e'(sel_q[k_q]);
  assign coef    = coef_lut(sel_cur);
  assign x_cur   = snap_q[k_q];
  assign y_wb    = (sel_cur == BYPASS) ? x_cur : sat16(acc);

  // Operands are presented one state ahead of the accumulate because the product is registered.
  always_comb begin
    mac_a  = '0;
    mac_b  = '0;
    mac_op = MAC_HOLD;
    case (state_q)
      LOAD: begin mac_a = x_cur;           mac_b = CW'(coef.b1); end
      MB1:  begin mac_a = x1_q[k_q];       mac_b = CW'(coef.b2); mac_op = MAC_CLR_ADD; end
      MB2:  begin mac_a = y1_q[k_q];       mac_b = CW'(coef.a2); mac_op = MAC_ADD; end
      MA2:  mac_op = MAC_SUB;
      default: ;
    endcase
  end

  gyruss_iir_mac #(.CW(CW)) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mac_a),
    .b       (mac_b),
    .op      (mac_op),
    .acc     (acc)
  );

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    k_d     = k_q;
    snap_d  = snap_q;
    sel_d   = sel_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    res_d   = res_q;
    out_d   = out_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q | (tick && state_q != IDLE);
    case (state_q)
      IDLE: if (tick) begin
        snap_d  = bus.in_flat;
        sel_d   = bus.sel_flat;
        k_d     = '0;
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: state_d = MB1;
      MB1:  state_d = MB2;
      MB2:  state_d = MA2;
      MA2:  state_d = WB;
      WB: begin
        x1_d[k_q]  = x_cur;
        y1_d[k_q]  = y_wb;
        res_d[k_q] = y_wb;
        if (k_q == KW'(NCH-1)) state_d = PUB;
        else begin
          k_d     = k_q + 1'b1;
          state_d = LOAD;
        end
      end
      PUB: begin
        out_d   = res_q;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      k_q     <= '0;
      snap_q  <= '0;
      sel_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      k_q     <= k_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      res_q   <= res_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_flat  = out_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_gyruss_lpf_scheduler.sv
// Directed bench: instance A (DIV=40) for filtering/latency/reset, instance B (DIV=20) for overrun.
module tb_gyruss_lpf_scheduler;
  localparam int NCH   = 5;
  localparam int DIV_A = 40;
  localparam int DIV_B = 20;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_run   = 0;
  int   n_fail  = 0;

  gyruss_lpf_scheduler_if #(.NCH(NCH)) bus_a ();
  gyruss_lpf_scheduler_if #(.NCH(NCH)) bus_b ();

  gyruss_lpf_scheduler #(.NCH(NCH), .DIV(DIV_A), .CW(18)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  gyruss_lpf_scheduler #(.NCH(NCH), .DIV(DIV_B), .CW(18)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int out_a(input int k);
    return int'($signed(bus_a.out_flat[16*k +: 16]));
  endfunction

  task automatic set_ch(input int k, input int val, input int sel);
    bus_a.in_flat[16*k +: 16] = 16'(val);
    bus_a.sel_flat[2*k +: 2]  = 2'(sel);
  endtask

  task automatic clear_inputs;
    bus_a.in_flat = '0; bus_a.sel_flat = '0;
    bus_b.in_flat = '0; bus_b.sel_flat = '0;
  endtask

  task automatic do_reset;
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid_a(input int budget, output bit ok);
    int cyc;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk); cyc++;
      if (bus_a.out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int seen;
    seen = 0;
    @(negedge clk); reset_n = 1'b0;
    repeat (2*DIV_A) begin
      bus_a.in_flat  = 80'({$urandom(), $urandom(), $urandom()});
      bus_a.sel_flat = 10'($urandom());
      @(negedge clk);
      if (bus_a.out_valid || bus_b.out_valid || bus_a.busy) seen++;
    end
    n_run++; if (seen !== 0) begin n_fail++; $display("FAIL reset_quiet: %0d active cycles, want 0", seen); end
    n_run++; if (bus_a.out_flat !== '0) begin n_fail++; $display("FAIL reset_out_flat: got %h want 0", bus_a.out_flat); end
    n_run++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_run++; if (bus_a.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus_a.overrun); end
    reset_n = 1'b1;
  endtask

  task automatic test_medium_step;
    bit ok;
    clear_inputs(); set_ch(0, 16384, 2);
    do_reset();
    wait_valid_a(DIV_A + 40, ok);
    n_run++; if (!ok) begin n_fail++; $display("FAIL step_valid1: timeout"); end
    n_run++; if (out_a(0) !== 87) begin n_fail++; $display("FAIL step_tick1: got %0d want 87", out_a(0)); end
    wait_valid_a(DIV_A + 40, ok);
    n_run++; if (!ok) begin n_fail++; $display("FAIL step_valid2: timeout"); end
    n_run++; if (out_a(0) !== 260) begin n_fail++; $display("FAIL step_tick2: got %0d want 260", out_a(0)); end
  endtask

  task automatic test_bypass;
    bit ok;
    int dev;
    clear_inputs(); set_ch(2, -1234, 0);
    do_reset();
    wait_valid_a(DIV_A + 40, ok);
    n_run++; if (!ok || out_a(2) !== -1234) begin n_fail++; $display("FAIL bypass_first: got %0d want -1234 (valid=%b)", out_a(2), ok); end
    set_ch(2, -1234, 2);
    dev = 0;
    repeat (10) begin
      wait_valid_a(DIV_A + 40, ok);
      if (!ok || out_a(2) > -1233 || out_a(2) < -1235) dev++;
    end
    n_run++; if (dev !== 0) begin n_fail++; $display("FAIL bypass_to_medium: %0d frames off by >1 LSB, want 0", dev); end
  endtask

  task automatic test_independence;
    bit ok;
    int n, y_m, x1_m, prev;
    longint acc_m;
    clear_inputs();
    set_ch(0, 16384, 2); set_ch(1, -32768, 0); set_ch(4, 0, 3);
    do_reset();
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus_a.out_valid) ok = 1'b1;
    end
    // Tick is in the cycle after posedge DIV-1; out_valid lands 27 cycles later.
    n_run++; if (!ok || n !== DIV_A + 26) begin n_fail++; $display("FAIL latency: valid after posedge %0d want %0d", n, DIV_A + 26); end
    n_run++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_pub: got %b want 0", bus_a.busy); end
    y_m = 0; x1_m = 0; prev = -40000;
    for (int f = 0; f < 800; f++) begin
      if (f > 0) begin
        wait_valid_a(DIV_A + 40, ok);
        if (!ok) begin n_run++; n_fail++; $display("FAIL indep_valid: timeout at frame %0d", f); end
      end
      acc_m = 64'sd174 * 16384 + 64'sd174 * x1_m + 64'sd32420 * y_m;
      y_m   = int'(acc_m >>> 15);
      x1_m  = 16384;
      n_run++; if (out_a(0) !== y_m) begin n_fail++; if (n_fail < 20) $display("FAIL indep_ch0 f%0d: got %0d want %0d", f, out_a(0), y_m); end
      n_run++; if (out_a(1) !== -32768) begin n_fail++; if (n_fail < 20) $display("FAIL indep_ch1 f%0d: got %0d want -32768", f, out_a(1)); end
      n_run++; if (out_a(4) !== 0) begin n_fail++; if (n_fail < 20) $display("FAIL indep_ch4 f%0d: got %0d want 0", f, out_a(4)); end
      n_run++; if (out_a(0) < prev) begin n_fail++; if (n_fail < 20) $display("FAIL monotonic f%0d: got %0d after %0d", f, out_a(0), prev); end
      prev = out_a(0);
    end
    // Floor shift leaves a deadband: the step settles where 348*(16384-y) < 32768.
    n_run++; if (out_a(0) < 16290 || out_a(0) > 16384) begin n_fail++; $display("FAIL settle: got %0d want 16290..16384", out_a(0)); end
  endtask

  task automatic test_overrun;
    int pulses, highs;
    logic prev_v;
    clear_inputs();
    bus_b.in_flat[15:0] = 16'd16384; bus_b.sel_flat[1:0] = 2'd2;
    do_reset();
    pulses = 0; highs = 0; prev_v = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 39) begin n_run++; if (bus_b.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b want 0", bus_b.overrun); end end
      if (n == 40) begin n_run++; if (bus_b.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", bus_b.overrun); end end
      if (bus_b.out_valid) highs++;
      if (bus_b.out_valid && !prev_v) pulses++;
      prev_v = bus_b.out_valid;
    end
    n_run++; if (pulses !== 4) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 4", pulses); end
    n_run++; if (highs !== 4) begin n_fail++; $display("FAIL overrun_width: got %0d high cycles want 4", highs); end
    n_run++; if (bus_b.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", bus_b.overrun); end
    do_reset();
    n_run++; if (bus_b.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", bus_b.overrun); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    clear_inputs(); set_ch(0, 16384, 2);
    do_reset();
    // Second tick lands after posedge 79, so T+12 is the cycle after posedge 91.
    for (int n = 1; n <= 91; n++) begin
      @(posedge clk); @(negedge clk);
    end
    n_run++; if (bus_a.busy !== 1'b1 || out_a(0) !== 87) begin n_fail++; $display("FAIL mid_pre: busy=%b out0=%0d want 1/87", bus_a.busy, out_a(0)); end
    reset_n = 1'b0;
    #1;
    n_run++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus_a.busy); end
    n_run++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", bus_a.out_valid); end
    n_run++; if (bus_a.out_flat !== '0) begin n_fail++; $display("FAIL mid_out_flat: got %h want 0", bus_a.out_flat); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_valid_a(DIV_A + 40, ok);
    n_run++; if (!ok || out_a(0) !== 87) begin n_fail++; $display("FAIL mid_restart: got %0d want 87 (valid=%b)", out_a(0), ok); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_medium_step();
    test_bypass();
    test_independence();
    test_overrun();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
